uart_msg_sequencer: RTL

UART_MSG_SEQUENCER -- requirements
Module: uart_msg_sequencer

---
 rtl/uart_msg_sequencer_pkg.sv | 46 ++++
 rtl/uart_msg_sequencer_loc_lut.sv | 31 +++
 rtl/uart_msg_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_sequencer_pkg.sv
// Shared constants for the UART message sequencer: node IDs, ASCII codes,
// header table, request record and FSM state encoding.
package uart_msg_sequencer_pkg;

    typedef logic [7:0] char_t;

    typedef struct packed {
        logic [1:0] typ;
        logic [4:0] node;
    } req_t;

    localparam char_t ASC_DASH = 8'h2D;
    localparam char_t ASC_HASH = 8'h23;
    localparam char_t ASC_ZERO = 8'h30;
    localparam char_t ASC_A    = 8'h41;

    localparam logic [4:0] NODE_PSU1 = 5'd27;
    localparam logic [4:0] NODE_PSU2 = 5'd29;
    localparam logic [4:0] NODE_PSU3 = 5'd31;
    localparam logic [4:0] NODE_MU1  = 5'd9;
    localparam logic [4:0] NODE_MU2  = 5'd8;
    localparam logic [4:0] NODE_MU3  = 5'd7;
    localparam logic [4:0] NODE_FSU1 = 5'd25;
    localparam logic [4:0] NODE_FSU2 = 5'd22;
    localparam logic [4:0] NODE_FSU3 = 5'd20;
    localparam logic [4:0] NODE_WSU1 = 5'd17;
    localparam logic [4:0] NODE_WSU2 = 5'd15;
    localparam logic [4:0] NODE_WSU3 = 5'd13;

    // Three-letter headers, first character in the top byte.
    localparam logic [23:0] HDR_TBL [4] = '{"RDM", "ARV", "DEP", "ERR"};

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam int MAX_LEN = 12;

    function automatic char_t hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? ASC_ZERO + {4'h0, nib} : ASC_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_msg_sequencer_loc_lut.sv
// Node number to location text (3 or 4 characters, first char in the top byte).
module msg_loc_lut
    import uart_msg_sequencer_pkg::*;
(
    input  logic [4:0]  i_node,
    output logic [31:0] o_loc,
    output logic        o_loc4
);

    // NOTE: both outputs get a default first so no path through the case can infer a latch.
    always_comb begin
        o_loc  = {"XXX", 8'h00};
        o_loc4 = 1'b0;
        case (i_node)
            NODE_PSU1: begin o_loc = "PSU1"; o_loc4 = 1'b1; end
            NODE_PSU2: begin o_loc = "PSU2"; o_loc4 = 1'b1; end
            NODE_PSU3: begin o_loc = "PSU3"; o_loc4 = 1'b1; end
            NODE_MU1:  o_loc = {"MU1", 8'h00};
            NODE_MU2:  o_loc = {"MU2", 8'h00};
            NODE_MU3:  o_loc = {"MU3", 8'h00};
            NODE_FSU1: begin o_loc = "FSU1"; o_loc4 = 1'b1; end
            NODE_FSU2: begin o_loc = "FSU2"; o_loc4 = 1'b1; end
            NODE_FSU3: begin o_loc = "FSU3"; o_loc4 = 1'b1; end
            NODE_WSU1: begin o_loc = "WSU1"; o_loc4 = 1'b1; end
            NODE_WSU2: begin o_loc = "WSU2"; o_loc4 = 1'b1; end
            NODE_WSU3: begin o_loc = "WSU3"; o_loc4 = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Queues status requests and streams each as "HDR-LOC-[HH]#" one character
// at a time to a UART, with optional inter-character gap and tx_done timeout.
module uart_msg_sequencer
    import uart_msg_sequencer_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int CKSUM_EN  = 0,
    parameter int GAP_CYC   = 0,
    parameter int TO_CYC    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_type,
    input  logic [4:0] req_node,
    output logic       req_ready,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_msg,
    output logic       busy,
    output logic       msg_done,
    output logic       timeout_err
);

    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TO_CYC + 1);

    req_t             r_mem [REQ_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop;

    logic [2:0]       r_state;
    req_t             r_cur;
    char_t            r_buf [MAX_LEN];
    logic [3:0]       r_len, r_idx;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_gap_cnt;
    char_t            r_tx_msg;
    logic             r_timeout;

    logic [31:0]      w_loc;
    logic             w_loc4;
    logic [23:0]      w_hdr;
    char_t            w_buf [MAX_LEN];
    logic [3:0]       w_dash2, w_len, w_idx_inc;
    char_t            w_cksum;

    assign req_ready = (r_count != CNT_W'(REQ_DEPTH));
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
    assign w_idx_inc = r_idx + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; pointers, count and state decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{typ: req_type, node: req_node};
        if (r_state == ST_LOAD) r_buf <= w_buf;
    end

    msg_loc_lut u_loc (
        .i_node (r_cur.node),
        .o_loc  (w_loc),
        .o_loc4 (w_loc4)
    );

    always_comb begin
        w_hdr   = HDR_TBL[r_cur.typ];
        w_cksum = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) w_buf[i] = 8'h00;
        w_buf[0] = w_hdr[23:16];
        w_buf[1] = w_hdr[15:8];
        w_buf[2] = w_hdr[7:0];
        w_buf[3] = ASC_DASH;
        w_buf[4] = w_loc[31:24];
        w_buf[5] = w_loc[23:16];
        w_buf[6] = w_loc[15:8];
        if (w_loc4) begin
            w_buf[7] = w_loc[7:0];
            w_buf[8] = ASC_DASH;
            w_dash2  = 4'd8;
        end else begin
            w_buf[7] = ASC_DASH;
            w_dash2  = 4'd7;
        end
        // Checksum spans the header through the second dash inclusive.
        for (int i = 0; i < 9; i++) begin
            if (i <= int'(w_dash2)) w_cksum = w_cksum ^ w_buf[i];
        end
        if (CKSUM_EN != 0) begin
            w_buf[w_dash2 + 4'd1] = hex_char(w_cksum[7:4]);
            w_buf[w_dash2 + 4'd2] = hex_char(w_cksum[3:0]);
            w_buf[w_dash2 + 4'd3] = ASC_HASH;
            w_len = w_dash2 + 4'd4;
        end else begin
            w_buf[w_dash2 + 4'd1] = ASC_HASH;
            w_len = w_dash2 + 4'd2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cur     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_tx_msg  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_pop) begin
                    r_cur   <= r_mem[r_rd_ptr];
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_len    <= w_len;
                    r_idx    <= '0;
                    r_tx_msg <= w_buf[0];
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    r_to_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        r_idx <= w_idx_inc;
                        if (w_idx_inc == r_len) begin
                            r_state <= ST_DONE;
                        end else if (GAP_CYC > 0) begin
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end else begin
                            r_tx_msg <= r_buf[w_idx_inc];
                            r_state  <= ST_SEND;
                        end
                    end else if (r_to_cnt == TO_W'(TO_CYC - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 8'(GAP_CYC - 1)) begin
                        r_tx_msg <= r_buf[r_idx];
                        r_state  <= ST_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_start    = (r_state == ST_SEND);
    assign tx_msg      = r_tx_msg;
    assign msg_done    = (r_state == ST_DONE);
    assign timeout_err = r_timeout;
    assign busy        = (r_state != ST_IDLE) || (r_count != '0);

endmodule
